dct2d_scheduler: RTL and testbench

Sequencing controller that runs a full 8x8 two-dimensional DCT on the shared 8-point 1-D DCT core. It accepts one row of eight samples per handshake, issues eight row transforms, and stores scaled results in an internal transpose buffer. It then issues eight column transforms and streams out one column of 2-D coefficients per handshake. It sits between the pixel-block fetch stage and the quantiser, and owns the 1-D core's `ena` and data inputs exclusively.

---
 rtl/dct_pkg.sv | 38 +++
 rtl/dct_transpose_buf.sv | 40 ++++
 rtl/dct2d_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dct2d_scheduler.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: lane widths, scheduler state encoding and the row-pass saturation
// helper shared by the 2-D DCT scheduler and its transpose buffer.
package dct_pkg;

    localparam int DCT_IN_W  = 9;
    localparam int DCT_OUT_W = 19;
    localparam int DCT_N     = 8;

    // Packed bus widths: eight input-width lanes and eight output-width lanes.
    localparam int DCT_ROW_W = DCT_N * DCT_IN_W;
    localparam int DCT_COL_W = DCT_N * DCT_OUT_W;

    typedef enum logic [1:0] {
        ROW_IN,
        ROW_RUN,
        COL_RUN,
        COL_OUT
    } dct_sched_state_t;

    localparam logic signed [DCT_OUT_W-1:0] SAT9_HI     = 19'sd255;
    localparam logic signed [DCT_OUT_W-1:0] SAT9_LO     = -19'sd256;
    localparam logic signed [DCT_IN_W-1:0]  SAT9_HI_OUT = 9'sh0ff;
    localparam logic signed [DCT_IN_W-1:0]  SAT9_LO_OUT = 9'sh100;

    // Clamp a row-pass value into the signed 9-bit range the column pass expects.
    function automatic logic signed [DCT_IN_W-1:0] sat9(input logic signed [DCT_OUT_W-1:0] x);
        logic signed [DCT_IN_W-1:0] y;
        if (x > SAT9_HI) begin
            y = SAT9_HI_OUT;
        end else if (x < SAT9_LO) begin
            y = SAT9_LO_OUT;
        end else begin
            y = x[DCT_IN_W-1:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: 8x8 array of 9-bit row-pass results. Rows are written
// whole; columns are read combinationally so the column pass can feed the core
// directly from the array.
module dct_transpose_buf
    import dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [2:0]           wr_row,
    input  logic [DCT_ROW_W-1:0] wr_data,
    input  logic [2:0]           rd_col,
    output logic [DCT_ROW_W-1:0] rd_data
);

    logic [DCT_IN_W-1:0] mem [DCT_N][DCT_N];

    // Row write: lane v of wr_data lands in column v of the addressed row.
    // NOTE: the array carries no reset; every entry is rewritten by the row
    // pass before the column pass reads it, so clearing it would only add logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int v = 0; v < DCT_N; v++) begin
                // NOTE: state updates use non-blocking assignment so every
                // register samples its inputs from before the edge.
                mem[wr_row][v] <= wr_data[v*DCT_IN_W +: DCT_IN_W];
            end
        end
    end

    // Column read: lane k of rd_data is row k of the selected column.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the output
        // unassigned and no latch is inferred.
        rd_data = '0;
        for (int k = 0; k < DCT_N; k++) begin
            rd_data[k*DCT_IN_W +: DCT_IN_W] = mem[k][rd_col];
        end
    end

endmodule

// File: rtl/dct2d_scheduler.sv
// dct2d_scheduler: runs an 8x8 2-D DCT on a shared 8-point 1-D core. Eight row
// transforms fill the transpose buffer with scaled, saturated results, then
// eight column transforms produce one coefficient column per output beat.
module dct2d_scheduler
    import dct_pkg::*;
#(
    parameter int ROW_SHIFT = 7,
    parameter int CORE_LAT  = 7
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DCT_ROW_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DCT_COL_W-1:0] out_data,
    output logic [2:0]           out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 core_ena,
    output logic [DCT_ROW_W-1:0] core_din,
    input  logic [DCT_COL_W-1:0] core_dout,
    output logic                 core_rst_n
);

    // Cycle, counted from the core start pulse, in which core outputs are valid.
    localparam logic [2:0] LAT_CYC = 3'(CORE_LAT);

    dct_sched_state_t state, state_next;

    logic [2:0]           row_cnt;
    logic [2:0]           col_cnt;
    logic [2:0]           cyc;
    logic [DCT_ROW_W-1:0] row_reg;
    logic [DCT_COL_W-1:0] out_reg;
    logic [DCT_ROW_W-1:0] row_wr_data;
    logic [DCT_ROW_W-1:0] col_rd_data;
    logic                 lat_hit;
    logic                 tb_wr_en;

    assign lat_hit  = (cyc == LAT_CYC);
    assign tb_wr_en = (state == ROW_RUN) && lat_hit;

    // Row-pass scaling: floor shift then clamp each core lane to 9 bits.
    for (genvar v = 0; v < DCT_N; v++) begin : g_row_scale
        logic signed [DCT_OUT_W-1:0] lane;
        assign lane = core_dout[v*DCT_OUT_W +: DCT_OUT_W];
        assign row_wr_data[v*DCT_IN_W +: DCT_IN_W] = sat9(lane >>> ROW_SHIFT);
    end

    dct_transpose_buf u_tbuf (
        .clk     (clk),
        .wr_en   (tb_wr_en),
        .wr_row  (row_cnt),
        .wr_data (row_wr_data),
        .rd_col  (col_cnt),
        .rd_data (col_rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ROW_IN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each run state waits for the core result cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ROW_IN: begin
                if (in_valid) state_next = ROW_RUN;
            end
            ROW_RUN: begin
                if (lat_hit) state_next = (row_cnt == 3'd7) ? COL_RUN : ROW_IN;
            end
            COL_RUN: begin
                if (lat_hit) state_next = COL_OUT;
            end
            COL_OUT: begin
                if (out_ready) state_next = (col_cnt == 3'd7) ? ROW_IN : COL_RUN;
            end
            default: state_next = ROW_IN;
        endcase
    end

    // Output decode: handshakes, core start pulse and core operand selection.
    // Handshake and status outputs are forced low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_ena  = 1'b0;
        busy      = 1'b0;
        core_din  = '0;
        if (!rst) begin
            unique case (state)
                ROW_IN:  in_ready  = 1'b1;
                ROW_RUN: core_ena  = (cyc == 3'd0);
                COL_RUN: core_ena  = (cyc == 3'd0);
                COL_OUT: out_valid = 1'b1;
                default: ;
            endcase
            busy = !((state == ROW_IN) && (row_cnt == 3'd0));
        end
        unique case (state)
            ROW_RUN: core_din = row_reg;
            COL_RUN: core_din = col_rd_data;
            default: ;
        endcase
    end

    assign out_last   = out_valid && (col_cnt == 3'd7);
    assign out_data   = out_reg;
    assign out_col    = col_cnt;
    assign core_rst_n = ~rst;

    // Datapath: row latch, run-cycle counter, row/column counters, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= 3'd0;
            col_cnt <= 3'd0;
            cyc     <= 3'd0;
            row_reg <= '0;
            out_reg <= '0;
        end else begin
            unique case (state)
                ROW_IN: begin
                    if (in_valid) begin
                        row_reg <= in_data;
                        cyc     <= 3'd0;
                    end
                end
                ROW_RUN: begin
                    cyc <= cyc + 3'd1;
                    if (lat_hit) begin
                        row_cnt <= row_cnt + 3'd1;
                        cyc     <= 3'd0;
                        if (row_cnt == 3'd7) col_cnt <= 3'd0;
                    end
                end
                COL_RUN: begin
                    cyc <= cyc + 3'd1;
                    if (lat_hit) begin
                        out_reg <= core_dout;
                        cyc     <= 3'd0;
                    end
                end
                COL_OUT: begin
                    if (out_ready) begin
                        col_cnt <= col_cnt + 3'd1;
                        cyc     <= 3'd0;
                        if (col_cnt == 3'd7) row_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dct2d_scheduler.sv
// tb_dct2d_scheduler: two schedulers (ROW_SHIFT 7 and 2) share stimulus; each
// drives its own behavioural 1-D core. Expected beats are queued by the
// stimulus and popped by a negedge monitor as the DUTs present them.
module tb_dct2d_scheduler;

    localparam int CORE_LAT = 7;
    localparam int SHIFT0   = 7;
    localparam int SHIFT1   = 2;

    typedef struct {
        logic [151:0] data;
        int           col;
        bit           timed;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [71:0]  in_data;
    logic         out_ready;
    logic         in_ready  [2];
    logic         out_valid [2];
    logic [151:0] out_data  [2];
    logic [2:0]   out_col   [2];
    logic         out_last  [2];
    logic         busy      [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_num = 0;
    int   blk_start = 0;
    int   blk [8][8];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_num <= cyc_num + 1;

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_num);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc_num);
    endtask

    // Core coefficient magnitudes for cos(a*pi/16), a = 1..8, DC gain 11.
    function automatic int cmag(input int a);
        case (a)
            1: return 15;
            2: return 14;
            3: return 13;
            4: return 11;
            5: return 9;
            6: return 6;
            7: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int coef(input int k, input int n);
        int a;
        if (k == 0) return 11;
        a = ((2 * n + 1) * k) % 32;
        if (a <= 8)       return cmag(a);
        else if (a <= 16) return -cmag(16 - a);
        else if (a <= 24) return -cmag(a - 16);
        else              return cmag(32 - a);
    endfunction

    // Bit-exact behavioural 1-D core: lane k = sum_n coef(k,n) * x[n].
    function automatic logic [151:0] core_model(input logic [71:0] din);
        logic [151:0] r;
        int           acc;
        int           x;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) begin
                x = $signed(din[9*n +: 9]);
                acc += coef(k, n) * x;
            end
            r[19*k +: 19] = acc[18:0];
        end
        return r;
    endfunction

    function automatic logic [71:0] pack_row(input int r);
        logic [71:0] d;
        int          v;
        for (int n = 0; n < 8; n++) begin
            v = blk[r][n];
            d[9*n +: 9] = v[8:0];
        end
        return d;
    endfunction

    // DUT instances, each with its own core model and core-contract monitor.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         core_ena;
        logic [71:0]  core_din;
        logic [151:0] core_dout;
        logic         core_rst_n;
        logic [151:0] res;
        logic [159:0] junk;
        int           cnt = -1;
        int           ena_cnt = 0;
        int           last_ena = -1;
        bit           chk_din = 1'b0;
        logic [71:0]  din_q;

        dct2d_scheduler #(
            .ROW_SHIFT (g == 0 ? SHIFT0 : SHIFT1),
            .CORE_LAT  (CORE_LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready[g]),
            .in_data    (in_data),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready),
            .out_data   (out_data[g]),
            .out_col    (out_col[g]),
            .out_last   (out_last[g]),
            .busy       (busy[g]),
            .core_ena   (core_ena),
            .core_din   (core_din),
            .core_dout  (core_dout),
            .core_rst_n (core_rst_n)
        );

        // Core: result visible only in cycle t+CORE_LAT; random junk otherwise.
        always @(posedge clk) begin
            junk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            if (!core_rst_n) begin
                cnt       <= -1;
                core_dout <= '0;
            end else if (core_ena) begin
                res       <= core_model(core_din);
                cnt       <= CORE_LAT - 1;
                core_dout <= junk[151:0];
            end else begin
                core_dout <= (cnt == 1) ? res : junk[151:0];
                if (cnt >= 0) cnt <= cnt - 1;
            end
        end

        // Core contract: operands held one cycle past ena, pulses spaced out.
        always @(negedge clk) begin
            if (rst) begin
                last_ena <= -1;
                chk_din  <= 1'b0;
            end else begin
                if (chk_din) check($sformatf("dut%0d_core_din_hold", g), core_din, din_q);
                chk_din <= core_ena;
                din_q   <= core_din;
                if (core_ena) begin
                    ena_cnt <= ena_cnt + 1;
                    if (last_ena >= 0)
                        check($sformatf("dut%0d_ena_spacing", g),
                              (cyc_num - last_ena) >= (CORE_LAT + 1), 1'b1);
                    last_ena <= cyc_num;
                end
            end
        end
    end

    // Output monitor: pops expectations on each accepted beat, checks stalls.
    bit           stall_prev [2];
    logic [151:0] stall_data [2];
    logic [2:0]   stall_col  [2];

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst) begin
            stall_prev[0] = 1'b0;
            stall_prev[1] = 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (out_valid[g]) begin
                    if (stall_prev[g]) begin
                        check($sformatf("dut%0d_stall_data", g), out_data[g], stall_data[g]);
                        check($sformatf("dut%0d_stall_col", g), out_col[g], stall_col[g]);
                    end
                    if (out_ready) begin
                        stall_prev[g] = 1'b0;
                        have = (g == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (!have) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL dut%0d_unexpected_beat: got col %0d with nothing expected", g, out_col[g]);
                        end else begin
                            if (g == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            check($sformatf("dut%0d_beat%0d_data", g, e.col), out_data[g], e.data);
                            check($sformatf("dut%0d_beat_col", g), out_col[g], e.col);
                            check($sformatf("dut%0d_beat_last", g), out_last[g], e.col == 7);
                            if (e.timed)
                                check($sformatf("dut%0d_beat%0d_cycle", g, e.col), cyc_num,
                                      blk_start + 80 + 9 * e.col);
                        end
                    end else begin
                        stall_prev[g] = 1'b1;
                        stall_data[g] = out_data[g];
                        stall_col[g]  = out_col[g];
                    end
                end else begin
                    stall_prev[g] = 1'b0;
                    check($sformatf("dut%0d_last_idle", g), out_last[g], 1'b0);
                end
            end
        end
    end

    // Hand-computed constant block: only beat 0 lane 0 is non-zero.
    task automatic push_dc(input int v0, input int v1, input bit timed);
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            e.col   = j;
            e.timed = timed;
            e.data  = '0;
            if (j == 0) e.data[18:0] = v0[18:0];
            q0.push_back(e);
            e.data  = '0;
            if (j == 0) e.data[18:0] = v1[18:0];
            q1.push_back(e);
        end
    endtask

    // Reference 2-D transform of blk for each DUT's row shift.
    task automatic push_model(input bit timed, input int nbeats);
        int           tbm [8][8];
        logic [151:0] rr;
        logic [71:0]  cin;
        int           x;
        int           s;
        exp_t         e;
        for (int g = 0; g < 2; g++) begin
            s = (g == 0) ? SHIFT0 : SHIFT1;
            for (int r = 0; r < 8; r++) begin
                rr = core_model(pack_row(r));
                for (int v = 0; v < 8; v++) begin
                    x = $signed(rr[19*v +: 19]);
                    x = x >>> s;
                    if (x > 255)  x = 255;
                    if (x < -256) x = -256;
                    tbm[r][v] = x;
                end
            end
            for (int j = 0; j < nbeats; j++) begin
                for (int k = 0; k < 8; k++) begin
                    x = tbm[k][j];
                    cin[9*k +: 9] = x[8:0];
                end
                e.data  = core_model(cin);
                e.col   = j;
                e.timed = timed;
                if (g == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++)
                blk[r][n] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++)
                blk[r][n] = int'($urandom_range(0, 511)) - 256;
    endtask

    // Present one row and hold it until accepted; busy must be low only for row 0.
    task automatic send_row(input int r);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = pack_row(r);
        @(negedge clk);
        while (!in_ready[0] && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            timeout($sformatf("row%0d_accept", r));
        end else begin
            if (r == 0) blk_start = cyc_num;
            check($sformatf("dut0_busy_row%0d", r), busy[0], r != 0);
            check($sformatf("dut1_busy_row%0d", r), busy[1], r != 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait until the scheduler is back in ROW_IN; returns the cycle seen.
    task automatic wait_ready(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[0] && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) timeout("in_ready_return");
        c = cyc_num;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int gap_row, input int gap_len);
        int c;
        for (int r = 0; r < 8; r++) begin
            if (r == gap_row) begin
                in_valid = 1'b0;
                wait_ready(c);
                repeat (gap_len) @(posedge clk);
                #1;
            end
            send_row(r);
        end
        in_valid = 1'b0;
    endtask

    // Wait for COL_RUN of the given column (column index shown, no beat yet).
    task automatic wait_col_run(input int col, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_col[0] == 3'(col) && !out_valid[0]) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        ok = (n < 2000);
        if (!ok) timeout($sformatf("col%0d_run", col));
    endtask

    task automatic full_block_checks(input string name, input int e0, input int e1);
        check({name, "_ena_count0"}, g_dut[0].ena_cnt - e0, 16);
        check({name, "_ena_count1"}, g_dut[1].ena_cnt - e1, 16);
        check({name, "_q_drained"}, q0.size() + q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int e0;
        int e1;
        bit ok;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready[0], 1'b0);
        check("rst_out_valid", out_valid[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_core_ena", g_dut[0].core_ena, 1'b0);
        check("rst_core_rst_n", g_dut[0].core_rst_n, 1'b0);
        check("rst_core_din", g_dut[0].core_din, 72'd0);
        check("rst_out_data", out_data[0], 152'd0);
        check("rst_out_col", out_col[0], 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready0", in_ready[0], 1'b1);
        check("post_rst_in_ready1", in_ready[1], 1'b1);
        check("post_rst_busy", busy[0], 1'b0);
        check("post_rst_core_rst_n", g_dut[0].core_rst_n, 1'b1);
        @(posedge clk);
        #1;

        // All 100, no stalls: DC only, exact beat timing and in_ready return.
        fill_const(100);
        push_dc(5984, 22440, 1'b1);
        e0 = g_dut[0].ena_cnt;
        e1 = g_dut[1].ena_cnt;
        send_block(-1, 0);
        wait_ready(c);
        check("in_ready_return_cycle", c, blk_start + 144);
        full_block_checks("b100", e0, e1);

        // All -100: floor of -8800/128 is -69.
        fill_const(-100);
        push_dc(-6072, -22528, 1'b1);
        e0 = g_dut[0].ena_cnt;
        e1 = g_dut[1].ena_cnt;
        send_block(-1, 0);
        wait_ready(c);
        full_block_checks("bm100", e0, e1);

        // All 255: saturates in the shift-2 instance only.
        fill_const(255);
        push_dc(15400, 22440, 1'b1);
        e0 = g_dut[0].ena_cnt;
        e1 = g_dut[1].ena_cnt;
        send_block(-1, 0);
        wait_ready(c);
        full_block_checks("b255", e0, e1);

        // Random block with an input gap before row 4 and a 3-cycle stall on beat 2.
        fill_rand();
        push_model(1'b0, 8);
        e0 = g_dut[0].ena_cnt;
        e1 = g_dut[1].ena_cnt;
        send_block(4, 5);
        wait_col_run(2, ok);
        if (ok) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            c = 0;
            @(negedge clk);
            while (!out_valid[0] && c < 100) begin
                c++;
                @(negedge clk);
            end
            if (c >= 100) timeout("stall_beat2");
            repeat (3) @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_ready(c);
        full_block_checks("bstall", e0, e1);

        // Random block, reset during COL_RUN of column 4: beats 0..3 only.
        fill_rand();
        push_model(1'b0, 4);
        send_block(-1, 0);
        wait_col_run(4, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready[0], 1'b0);
        check("midrst_out_valid", out_valid[0], 1'b0);
        check("midrst_core_rst_n", g_dut[0].core_rst_n, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready0", in_ready[0], 1'b1);
        check("after_rst_in_ready1", in_ready[1], 1'b1);
        check("after_rst_out_valid0", out_valid[0], 1'b0);
        check("after_rst_out_valid1", out_valid[1], 1'b0);
        check("after_rst_busy0", busy[0], 1'b0);
        check("after_rst_busy1", busy[1], 1'b0);
        check("after_rst_q_drained", q0.size() + q1.size(), 0);
        @(posedge clk);
        #1;

        // Two random blocks after the reset, no stalls.
        for (int b = 0; b < 2; b++) begin
            fill_rand();
            push_model(1'b1, 8);
            e0 = g_dut[0].ena_cnt;
            e1 = g_dut[1].ena_cnt;
            send_block(-1, 0);
            wait_ready(c);
            check($sformatf("rand%0d_in_ready_return_cycle", b), c, blk_start + 144);
            full_block_checks($sformatf("rand%0d", b), e0, e1);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
